// File: rtl/memory_access_stage.sv
// MEM pipeline stage: data-memory req/resp handshake, store lane alignment,
// load sign/zero extension and the MEM/WB register.
package rv32i_types_pkg;
    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic       load_regfile;
        logic       mem_read;
        logic       mem_write;
    } rv32i_control_word;
endpackage

module memory_access_stage
    import rv32i_types_pkg::*;
#(
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  rv32i_control_word ctrl_word_in,
    input  logic [31:0]       instruction_in,
    input  logic [31:0]       PC_in,
    input  logic [31:0]       alu_in,
    input  logic [31:0]       rs2_in,
    input  logic              br_en_in,
    output logic              stall_out,
    output logic              data_read,
    output logic              data_write,
    output logic [3:0]        data_mbe,
    output logic [31:0]       data_addr,
    output logic [31:0]       data_wdata,
    input  logic [31:0]       data_rdata,
    input  logic              data_resp,
    output logic              valid_out,
    output rv32i_control_word ctrl_word_out,
    output logic [31:0]       instruction_out,
    output logic [31:0]       PC_out,
    output logic [31:0]       alu_out,
    output logic              br_en_out,
    output logic [31:0]       rdata_out,
    output logic              misalign_out
);

    typedef enum logic {IDLE, REQ} state_t;

    function automatic logic [3:0] store_mbe(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   store_mbe = 4'b0001 << off;
            2'b01:   store_mbe = 4'b0011 << off;
            default: store_mbe = 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] rs2);
        case (size)
            2'b00:   store_wdata = {4{rs2[7:0]}};
            2'b01:   store_wdata = {2{rs2[15:0]}};
            default: store_wdata = rs2;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {off, 3'b000});
        h = 16'(w >> {off[1], 4'b0000});
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b100:  load_extend = {24'h0, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b101:  load_extend = {16'h0, h};
            default: load_extend = w;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic [3:0]        mbe_q, mbe_d;
    logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic              valid_q, valid_d, br_q, br_d, mis_q, mis_d;
    rv32i_control_word ctrl_q, ctrl_d;
    logic [31:0]       instr_q, instr_d, pc_q, pc_d, alu_q, alu_d, rdata_q, rdata_d;

    logic [1:0] size, a_lo, off;
    logic       is_mem, misaligned, trap, mem_op, stall_c;

    assign size       = ctrl_word_in.funct3[1:0];
    assign a_lo       = alu_in[1:0];
    assign is_mem     = ctrl_word_in.mem_read | ctrl_word_in.mem_write;
    assign misaligned = (size == 2'b01 && a_lo[0]) || (size == 2'b10 && a_lo != 2'b00);
    assign trap       = MISALIGN_TRAP && misaligned;
    assign mem_op     = valid_in && is_mem && !trap;
    // Non-trapping misaligned accesses simply drop the offending low address bits.
    assign off        = (size == 2'b00) ? a_lo : (size == 2'b01) ? {a_lo[1], 1'b0} : 2'b00;

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        mbe_d   = mbe_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        off_d   = off_q;
        stall_c = 1'b0;
        ctrl_d  = ctrl_word_in;
        instr_d = instruction_in;
        pc_d    = PC_in;
        alu_d   = alu_in;
        br_d    = br_en_in;
        valid_d = 1'b0;
        mis_d   = 1'b0;
        rdata_d = 32'h0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    state_d = REQ;
                    rd_d    = ctrl_word_in.mem_read;
                    wr_d    = ctrl_word_in.mem_write & ~ctrl_word_in.mem_read;
                    addr_d  = {alu_in[31:2], 2'b00};
                    mbe_d   = ctrl_word_in.mem_read ? 4'hF : store_mbe(size, off);
                    wdata_d = ctrl_word_in.mem_read ? 32'h0 : store_wdata(size, rs2_in);
                    f3_d    = ctrl_word_in.funct3;
                    off_d   = off;
                    stall_c = 1'b1;
                end else begin
                    valid_d = valid_in;
                    mis_d   = valid_in && is_mem && trap;
                end
            end
            REQ: begin
                stall_c = ~data_resp;
                if (data_resp) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    valid_d = valid_in;
                    rdata_d = rd_q ? load_extend(f3_q, off_q, data_rdata) : 32'h0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            mbe_q   <= 4'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            f3_q    <= 3'h0;
            off_q   <= 2'h0;
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            instr_q <= 32'h0;
            pc_q    <= 32'h0;
            alu_q   <= 32'h0;
            br_q    <= 1'b0;
            rdata_q <= 32'h0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            mbe_q   <= mbe_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            alu_q   <= alu_d;
            br_q    <= br_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    assign stall_out       = rst & stall_c;
    assign data_read       = rd_q;
    assign data_write      = wr_q;
    assign data_mbe        = mbe_q;
    assign data_addr       = addr_q;
    assign data_wdata      = wdata_q;
    assign valid_out       = valid_q;
    assign ctrl_word_out   = ctrl_q;
    assign instruction_out = instr_q;
    assign PC_out          = pc_q;
    assign alu_out         = alu_q;
    assign br_en_out       = br_q;
    assign rdata_out       = rdata_q;
    assign misalign_out    = mis_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: vector table with scoreboard plus reset and stray-response sequences.
module tb_memory_access_stage;
    import rv32i_types_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, valid_in, br_en_in, data_resp;
    rv32i_control_word ctrl_word_in, ctrl_word_out;
    logic [31:0]       instruction_in, PC_in, alu_in, rs2_in, data_rdata;
    logic              stall_out, data_read, data_write, valid_out, br_en_out, misalign_out;
    logic [3:0]        data_mbe;
    logic [31:0]       data_addr, data_wdata, instruction_out, PC_out, alu_out, rdata_out;

    memory_access_stage #(.MISALIGN_TRAP(1'b1)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ctrl_word_in(ctrl_word_in),
        .instruction_in(instruction_in), .PC_in(PC_in), .alu_in(alu_in), .rs2_in(rs2_in),
        .br_en_in(br_en_in), .stall_out(stall_out), .data_read(data_read),
        .data_write(data_write), .data_mbe(data_mbe), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_resp(data_resp),
        .valid_out(valid_out), .ctrl_word_out(ctrl_word_out), .instruction_out(instruction_out),
        .PC_out(PC_out), .alu_out(alu_out), .br_en_out(br_en_out), .rdata_out(rdata_out),
        .misalign_out(misalign_out)
    );

    typedef struct {
        logic        vin;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          delay;
        logic        e_req;
        logic [31:0] e_addr;
        logic [3:0]  e_mbe;
        logic [31:0] e_wdata;
        int          e_stalls;
        logic        e_valid;
        logic [31:0] e_rdata;
        logic        e_mis;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        mis;
    } exp_t;

    vec_t        vt[14];
    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] pc       = 32'h0000_0100;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic vin, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] rs2);
        rv32i_control_word c;
        c              = '0;
        c.opcode       = rd ? 7'h03 : (wr ? 7'h23 : 7'h33);
        c.funct3       = f3;
        c.mem_read     = rd;
        c.mem_write    = wr;
        c.load_regfile = ~wr;
        ctrl_word_in   = c;
        valid_in       = vin;
        alu_in         = alu;
        rs2_in         = rs2;
        pc             = pc + 32'd4;
        PC_in          = pc;
        instruction_in = {pc[15:0], 16'h0013};
        br_en_in       = pc[2];
    endtask

    task automatic check_capture(input int idx);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty[%0d]: got no entry expected one", idx);
        end else begin
            e = sb_q.pop_front();
            chk($sformatf("valid_out[%0d]", idx), 32'(valid_out), 32'(e.valid));
            chk($sformatf("PC_out[%0d]", idx), PC_out, e.pc);
            chk($sformatf("alu_out[%0d]", idx), alu_out, e.alu);
            chk($sformatf("rdata_out[%0d]", idx), rdata_out, e.rdata);
            chk($sformatf("misalign_out[%0d]", idx), 32'(misalign_out), 32'(e.mis));
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        int   stalls, reqs;
        bit   done;
        drive(v.vin, v.rd, v.wr, v.f3, v.alu, v.rs2);
        e.valid = v.e_valid;
        e.pc    = pc;
        e.alu   = v.alu;
        e.rdata = v.e_rdata;
        e.mis   = v.e_mis;
        sb_q.push_back(e);
        stalls = 0;
        reqs   = 0;
        done   = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            if (cyc > 0) chk($sformatf("bubble[%0d]", idx), 32'(valid_out), 32'h0);
            if (data_read || data_write) begin
                reqs++;
                chk($sformatf("data_addr[%0d]", idx), data_addr, v.e_addr);
                if (reqs == 1) begin
                    chk($sformatf("data_read[%0d]", idx), 32'(data_read), 32'(v.rd));
                    chk($sformatf("data_write[%0d]", idx), 32'(data_write), 32'(v.wr));
                    chk($sformatf("data_mbe[%0d]", idx), 32'(data_mbe), 32'(v.e_mbe));
                    if (v.wr) chk($sformatf("data_wdata[%0d]", idx), data_wdata, v.e_wdata);
                end
                if (reqs == v.delay) begin
                    data_rdata = v.rdata;
                    data_resp  = 1'b1;
                end
            end
            #1;
            if (stall_out) stalls++;
            else done = 1'b1;
            @(posedge clk);
            #2;
            data_resp = 1'b0;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout[%0d]: got stall after 40 cycles expected completion", idx);
        end
        chk($sformatf("stall_cycles[%0d]", idx), 32'(stalls), 32'(v.e_stalls));
        chk($sformatf("req_issued[%0d]", idx), 32'(reqs != 0), 32'(v.e_req));
        check_capture(idx);
    endtask

    initial begin
        //          vin rd  wr  f3    alu           rs2           rdata         dly req addr          mbe      wdata         stl val rdata_out     mis
        vt[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 0, 1'b0, 32'h0, 4'h0, 32'h0, 0, 1'b1, 32'h0, 1'b0};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 4, 1'b1, 32'h0000_1000, 4'hF, 32'h0, 4, 1'b1, 32'hFFFF_FF80, 1'b0};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 1, 1'b1, 32'h0000_1000, 4'hF, 32'h0, 1, 1'b1, 32'h0000_0080, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'hAAAA_BEEF, 32'h0, 2, 1'b1, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 2, 1'b1, 32'h0, 1'b0};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 0, 1'b0, 32'h0, 4'h0, 32'h0, 0, 1'b1, 32'h0, 1'b1};
        vt[5]  = '{1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0, 1, 1'b1, 32'h0000_4000, 4'hF, 32'hDEAD_BEEF, 1, 1'b1, 32'h0, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 1, 1'b1, 32'h0000_4000, 4'hF, 32'h0, 1, 1'b1, 32'hCAFE_F00D, 1'b0};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 3'b001, 32'h0000_5002, 32'h0, 32'h8001_7FFF, 1, 1'b1, 32'h0000_5000, 4'hF, 32'h0, 1, 1'b1, 32'hFFFF_8001, 1'b0};
        vt[8]  = '{1'b1, 1'b1, 1'b0, 3'b101, 32'h0000_5002, 32'h0, 32'h8001_7FFF, 1, 1'b1, 32'h0000_5000, 4'hF, 32'h0, 1, 1'b1, 32'h0000_8001, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_6001, 32'h1234_5678, 32'h0, 1, 1'b1, 32'h0000_6000, 4'b0010, 32'h7878_7878, 1, 1'b1, 32'h0, 1'b0};
        vt[10] = '{1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_6000, 32'h0, 32'h0000_007F, 1, 1'b1, 32'h0000_6000, 4'hF, 32'h0, 1, 1'b1, 32'h0000_007F, 1'b0};
        vt[11] = '{1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_7001, 32'h5555_6666, 32'h0, 0, 1'b0, 32'h0, 4'h0, 32'h0, 0, 1'b1, 32'h0, 1'b1};
        vt[12] = '{1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_8000, 32'h0, 32'h0, 0, 1'b0, 32'h0, 4'h0, 32'h0, 0, 1'b0, 32'h0, 1'b0};
        vt[13] = '{1'b1, 1'b1, 1'b0, 3'b001, 32'h0000_9000, 32'h0, 32'h0000_8000, 3, 1'b1, 32'h0000_9000, 4'hF, 32'h0, 3, 1'b1, 32'hFFFF_8000, 1'b0};

        rst        = 1'b0;
        data_resp  = 1'b0;
        data_rdata = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        chk("reset_valid_out", 32'(valid_out), 32'h0);
        chk("reset_stall_out", 32'(stall_out), 32'h0);
        chk("reset_data_rw", 32'({data_read, data_write}), 32'h0);
        chk("reset_rdata_out", rdata_out, 32'h0);
        rst = 1'b1;

        // Reset landing while a load request is outstanding.
        drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0);
        @(posedge clk);
        #2;
        chk("midreq_data_read", 32'(data_read), 32'h1);
        #1;
        rst = 1'b0;
        #1;
        chk("midreq_rst_data_read", 32'(data_read), 32'h0);
        chk("midreq_rst_data_addr", data_addr, 32'h0);
        chk("midreq_rst_data_mbe", 32'(data_mbe), 32'h0);
        chk("midreq_rst_stall", 32'(stall_out), 32'h0);
        chk("midreq_rst_PC_out", PC_out, 32'h0);
        valid_in = 1'b0;
        @(posedge clk);
        #2;
        rst        = 1'b1;
        data_resp  = 1'b1;
        data_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #2;
        data_resp = 1'b0;
        chk("after_rst_valid_out", 32'(valid_out), 32'h0);
        chk("after_rst_data_read", 32'(data_read), 32'h0);
        chk("after_rst_rdata_out", rdata_out, 32'h0);

        for (int i = 0; i < 14; i++) run_vec(i, vt[i]);

        // Stray response while idle with a plain ALU op in the slot.
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_ABCD, 32'h0);
        sb_q.push_back('{1'b1, pc, 32'h0000_ABCD, 32'h0, 1'b0});
        data_resp  = 1'b1;
        data_rdata = 32'h1111_2222;
        #2;
        chk("stray_stall", 32'(stall_out), 32'h0);
        @(posedge clk);
        #2;
        data_resp = 1'b0;
        chk("stray_data_read", 32'({data_read, data_write}), 32'h0);
        check_capture(99);
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(posedge clk);
        #2;
        chk("stray_still_idle", 32'({data_read, data_write}), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
